// File: rtl/regpair_ctrl.sv
// 16-bit register-pair sequencer for the 8085 register file: RD/WR/INX/DCX
// using the 8-bit read/write ports over several cycles.
module regpair_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [1:0]            psel,
  input  logic [2*DATASIZE-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2*DATASIZE-1:0] dout,
  output logic                  wrenb,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DATASIZE-1:0]   wdata,
  output logic                  flenb,
  output logic [DATASIZE-1:0]   ifdat,
  output logic                  r1enb,
  output logic                  r2enb,
  output logic [ADDRSIZE-1:0]   r1add,
  output logic [ADDRSIZE-1:0]   r2add,
  input  logic [DATASIZE-1:0]   r1dat,
  input  logic [DATASIZE-1:0]   r2dat
);

  localparam int PW = 2 * DATASIZE;
  localparam logic [1:0] CMD_RD  = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_INX = 2'b10;
  localparam logic [1:0] CMD_DCX = 2'b11;

  // S_ACPT is the cycle after acceptance; it aligns the registered strobes
  // so the first register-file access lands one edge after the start edge.
  typedef enum logic [2:0] {
    S_IDLE, S_ACPT, S_READ, S_WLO, S_WHI, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d, psel_q, psel_d;
  logic                  ill_q, ill_d;
  logic [PW-1:0]         opr_q, opr_d, dout_q, dout_d, rd_pair;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  wrenb_q, wrenb_d, flenb_q, flenb_d;
  logic                  r1enb_q, r1enb_d, r2enb_q, r2enb_d;
  logic [ADDRSIZE-1:0]   waddr_q, waddr_d, r1add_q, r1add_d, r2add_q, r2add_d;
  logic [DATASIZE-1:0]   wdata_q, wdata_d, ifdat_q, ifdat_d;

  // PSW keeps A (7) as the high byte and F (6) as the low byte.
  function automatic logic [ADDRSIZE-1:0] hi_idx(input logic [1:0] p);
    return (p == 2'd3) ? ADDRSIZE'(7) : ADDRSIZE'({p, 1'b0});
  endfunction

  function automatic logic [ADDRSIZE-1:0] lo_idx(input logic [1:0] p);
    return (p == 2'd3) ? ADDRSIZE'(6) : ADDRSIZE'({p, 1'b1});
  endfunction

  assign rd_pair = {r1dat, r2dat};

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    psel_d  = psel_q;
    ill_d   = ill_q;
    opr_d   = opr_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: if (start) begin
        cmd_d   = cmd;
        psel_d  = psel;
        opr_d   = din;
        ill_d   = cmd[1] & (psel == 2'd3);
        state_d = S_ACPT;
      end
      S_ACPT: begin
        if (ill_q)                 state_d = S_DONE;
        else if (cmd_q == CMD_WR)  state_d = S_WLO;
        else                       state_d = S_READ;
      end
      S_READ: begin
        case (cmd_q)
          CMD_INX: opr_d = rd_pair + PW'(1);
          CMD_DCX: opr_d = rd_pair - PW'(1);
          default: opr_d = rd_pair;
        endcase
        state_d = (cmd_q == CMD_RD) ? S_DONE : S_WLO;
      end
      S_WLO:   state_d = S_WHI;
      S_WHI:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE && !ill_d)
      dout_d = opr_d;

    // Strobes are registered from the next state so they track state_q exactly.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = done_d & ill_d;
    wrenb_d = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    flenb_d = 1'b0;
    ifdat_d = '0;
    r1enb_d = 1'b0;
    r2enb_d = 1'b0;
    r1add_d = '0;
    r2add_d = '0;
    case (state_d)
      S_READ: begin
        r1enb_d = 1'b1;
        r2enb_d = 1'b1;
        r1add_d = hi_idx(psel_d);
        r2add_d = lo_idx(psel_d);
      end
      S_WLO: begin
        if (psel_d == 2'd3) begin
          flenb_d = 1'b1;
          ifdat_d = opr_d[DATASIZE-1:0];
        end else begin
          wrenb_d = 1'b1;
          waddr_d = lo_idx(psel_d);
          wdata_d = opr_d[DATASIZE-1:0];
        end
      end
      S_WHI: begin
        wrenb_d = 1'b1;
        waddr_d = hi_idx(psel_d);
        wdata_d = opr_d[PW-1:DATASIZE];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      psel_q  <= '0;
      ill_q   <= 1'b0;
      opr_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wrenb_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      flenb_q <= 1'b0;
      ifdat_q <= '0;
      r1enb_q <= 1'b0;
      r2enb_q <= 1'b0;
      r1add_q <= '0;
      r2add_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      psel_q  <= psel_d;
      ill_q   <= ill_d;
      opr_q   <= opr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wrenb_q <= wrenb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      flenb_q <= flenb_d;
      ifdat_q <= ifdat_d;
      r1enb_q <= r1enb_d;
      r2enb_q <= r2enb_d;
      r1add_q <= r1add_d;
      r2add_q <= r2add_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign dout  = dout_q;
  assign wrenb = wrenb_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign flenb = flenb_q;
  assign ifdat = ifdat_q;
  assign r1enb = r1enb_q;
  assign r2enb = r2enb_q;
  assign r1add = r1add_q;
  assign r2add = r2add_q;

endmodule

// File: tb/tb_regpair_ctrl.sv
// Bench for regpair_ctrl: register-file model around the DUT, directed
// scenarios plus random commands checked against a pair-level reference.
module tb_regpair_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cmd, psel;
  logic [15:0] din;
  logic        busy, done, err, wrenb, flenb, r1enb, r2enb;
  logic [15:0] dout;
  logic [2:0]  waddr, r1add, r2add;
  logic [7:0]  wdata, ifdat, r1dat, r2dat;

  regpair_ctrl #(.DATASIZE(8), .ADDRSIZE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .psel(psel), .din(din),
    .busy(busy), .done(done), .err(err), .dout(dout),
    .wrenb(wrenb), .waddr(waddr), .wdata(wdata), .flenb(flenb), .ifdat(ifdat),
    .r1enb(r1enb), .r2enb(r2enb), .r1add(r1add), .r2add(r2add),
    .r1dat(r1dat), .r2dat(r2dat)
  );

  always #5 clk = ~clk;

  // Register file: asynchronous read, write on the rising edge.
  bit [7:0]   regs [8];
  logic [11:0] wlog[$];   // {flag, addr, data} per write strobe
  int         rd_cyc = 0;

  assign r1dat = regs[r1add];
  assign r2dat = regs[r2add];

  always @(posedge clk) begin
    if (wrenb) begin
      regs[waddr] <= wdata;
      wlog.push_back({1'b0, waddr, wdata});
    end
    if (flenb) begin
      regs[6] <= ifdat;
      wlog.push_back({1'b1, 3'd0, ifdat});
    end
    if (r1enb || r2enb) rd_cyc <= rd_cyc + 1;
  end

  int n_chk = 0, n_err = 0;
  bit [7:0]  ref_regs [8];
  bit [15:0] ref_dout = 16'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_dut();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = regs[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_ref();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = ref_regs[i];
    return v;
  endfunction

  function automatic logic [47:0] out_vec();
    return {busy, done, err, wrenb, flenb, r1enb, r2enb, waddr, r1add, r2add,
            wdata, ifdat, dout};
  endfunction

  // Issue one command and check it against the pair-level model; with noise,
  // start is toggled with junk operands while the controller is busy.
  task automatic run_cmd(input logic [1:0] c, input logic [1:0] p,
                         input logic [15:0] d, input bit noise);
    int        hi, lo, lat, exp_lat, base, rd0, exp_nw, exp_rd;
    bit        ill;
    bit [15:0] pair, val;
    logic [11:0] e [2];
    hi   = (p == 2'd3) ? 7 : 2 * p;
    lo   = (p == 2'd3) ? 6 : 2 * p + 1;
    pair = {ref_regs[hi], ref_regs[lo]};
    ill  = (c >= 2'd2) && (p == 2'd3);
    case (c)
      2'd0: begin val = pair;      exp_lat = 2; end
      2'd1: begin val = d;         exp_lat = 3; end
      2'd2: begin val = pair + 1;  exp_lat = 4; end
      default: begin val = pair - 1; exp_lat = 4; end
    endcase
    if (ill) exp_lat = 1;
    exp_nw = (ill || c == 2'd0) ? 0 : 2;
    exp_rd = (ill || c == 2'd1) ? 0 : 1;
    e[0] = (p == 2'd3) ? {1'b1, 3'd0, val[7:0]} : {1'b0, 3'(lo), val[7:0]};
    e[1] = {1'b0, 3'(hi), val[15:8]};

    @(negedge clk);
    start = 1'b1; cmd = c; psel = p; din = d;
    base = wlog.size();
    rd0  = rd_cyc;
    @(posedge clk);
    @(negedge clk);
    start = noise ? 1'($urandom) : 1'b0;
    cmd = 2'($urandom); psel = 2'($urandom); din = 16'($urandom);
    chk("busy_after_start", busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (noise) begin
        start = 1'($urandom); cmd = 2'($urandom); psel = 2'($urandom); din = 16'($urandom);
      end
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("err", err, ill);
    chk("busy_in_done", busy, 1'b1);
    if (!ill) ref_dout = val;
    chk("dout", dout, ref_dout);
    chk("write_count", wlog.size() - base, exp_nw);
    for (int i = 0; i < exp_nw && base + i < wlog.size(); i++)
      chk("write_seq", wlog[base + i], e[i]);
    chk("read_cycles", rd_cyc - rd0, exp_rd);
    if (!ill && c != 2'd0) begin
      ref_regs[hi] = val[15:8];
      ref_regs[lo] = val[7:0];
    end
    chk("regfile", pack_dut(), pack_ref());
  endtask

  initial begin
    int hi_old;
    bit [15:0] hl;
    rst = 1'b1; start = 1'b0; cmd = '0; psel = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 48'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_vec(), 48'h0);

    for (int p = 0; p < 4; p++) run_cmd(2'd1, 2'(p), 16'($urandom), 1'b0);

    // Directed scenarios
    run_cmd(2'd1, 2'd1, 16'hA55A, 1'b0);
    chk("D_reg", regs[2], 8'hA5);
    chk("E_reg", regs[3], 8'h5A);
    run_cmd(2'd1, 2'd2, 16'h00FF, 1'b0);
    run_cmd(2'd2, 2'd2, 16'h0000, 1'b0);
    chk("inx_carry", dout, 16'h0100);
    run_cmd(2'd1, 2'd2, 16'hFFFF, 1'b0);
    run_cmd(2'd2, 2'd2, 16'h0000, 1'b0);
    chk("inx_wrap", dout, 16'h0000);
    run_cmd(2'd1, 2'd0, 16'h0000, 1'b0);
    run_cmd(2'd3, 2'd0, 16'h0000, 1'b0);
    chk("dcx_wrap", dout, 16'hFFFF);
    run_cmd(2'd3, 2'd3, 16'h1234, 1'b0);
    chk("illegal_dout_kept", dout, 16'hFFFF);
    run_cmd(2'd1, 2'd3, 16'h12D5, 1'b0);
    chk("A_reg", regs[7], 8'h12);
    chk("F_reg", regs[6], 8'hD5);
    run_cmd(2'd0, 2'd3, 16'h0000, 1'b1);
    chk("rd_psw", dout, 16'h12D5);

    // Reset while the high byte of an INX is being written
    run_cmd(2'd1, 2'd2, 16'h3456, 1'b0);
    hl = {ref_regs[4], ref_regs[5]} + 16'h1;
    hi_old = ref_regs[4];
    @(negedge clk);
    start = 1'b1; cmd = 2'd2; psel = 2'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("whi_strobe", {wrenb, waddr, wdata}, {1'b1, 3'd4, hl[15:8]});
    rst = 1'b1;
    #1;
    chk("async_reset", out_vec(), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_regs[5] = hl[7:0];
    ref_dout = 16'h0;
    chk("abort_hi_kept", regs[4], 8'(hi_old));
    chk("abort_regfile", pack_dut(), pack_ref());
    run_cmd(2'd0, 2'd2, 16'h0000, 1'b0);

    // Random commands, including illegal ones and start noise while busy
    for (int n = 0; n < 60; n++)
      run_cmd(2'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
